// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and FSM encoding for the nibble-serial adder.
package nibble_serial_adder_pkg;

  localparam int unsigned NIB_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter width for n nibble steps, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/nibble_add_cin.sv
// Combinational 4-bit ripple-carry adder with carry-in, built from full-adder cells.
module nibble_add_cin
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[NIB_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that streams operands LSB-nibble-first through one 4-bit slice.
// Handshake: a transfer happens on a rising edge where valid & ready are both high;
// in_ready is high only in IDLE, out_valid only in DONE, and results hold until taken.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [1:0]       dbg_state
);

  localparam int NNIB = WIDTH / NIB_W;
  localparam int CW   = cnt_width(NNIB);

  if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_width_check
    $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;

  logic [NIB_W-1:0] sl_a, sl_b, sl_sum;
  logic             sl_cout;

  assign sl_a = a_q[{cnt_q, 2'b00} +: NIB_W];
  assign sl_b = b_q[{cnt_q, 2'b00} +: NIB_W];

  nibble_add_cin u_slice (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = ST_ADD;
        end
      end
      ST_ADD: begin
        sum_d[{cnt_q, 2'b00} +: NIB_W] = sl_sum;
        carry_d = sl_cout;
        cnt_d   = cnt_q + 1'b1;
        // Last nibble: its sum bit 3 is the new MSB used for signed overflow.
        if (cnt_q == CW'(NNIB - 1)) begin
          cout_d  = sl_cout;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_sum[NIB_W-1] != a_q[WIDTH-1]);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (WIDTH=16): directed corner cases plus random ops.
module tb_nibble_serial_adder;

  localparam int W    = 16;
  localparam int NNIB = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic [1:0]   dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // Expected results packed as {ovf, cout, sum}.
  logic [W+1:0] exp_q[$];

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, unsigned for carry, signed for overflow.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    longint us, ss;
    logic [W-1:0] s;
    logic co, ov;
    us = longint'(x) + longint'(y) + longint'(c);
    ss = longint'($signed(x)) + longint'($signed(y)) + longint'(c);
    co = (us >= 65536);
    ov = (ss > 32767) || (ss < -32768);
    s  = us[W-1:0];
    return {ov, co, s};
  endfunction

  // Entered at the first falling edge after the accept edge.
  task automatic finish_op(input logic [W+1:0] e, input logic [W-1:0] post_a);
    int lat;
    in_valid = 1'b0;
    a   = post_a;
    b   = W'($urandom);
    cin = ~cin;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 20) begin
      n_vec++;
      if (in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL busy_in_ready: got %b want 0 (lat %0d)", in_ready, lat);
      end
      @(negedge clk);
      lat++;
    end
    n_vec++;
    if (lat !== NNIB) begin
      n_err++;
      $display("FAIL latency: got %0d want %0d", lat, NNIB);
    end
    n_vec++;
    if ({ovf, cout, sum} !== e) begin
      n_err++;
      $display("FAIL result: got ovf=%b cout=%b sum=%h want ovf=%b cout=%b sum=%h",
               ovf, cout, sum, e[W+1], e[W], e[W-1:0]);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL release: got out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input logic early_rdy, input logic [W+1:0] expv,
                        input logic [W-1:0] post_a);
    int guard;
    logic [W+1:0] e;
    exp_q.push_back(expv);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1; out_ready = early_rdy;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL accept: in_ready=%b want 1", in_ready);
    end
    @(negedge clk);
    e = exp_q.pop_front();
    finish_op(e, post_a);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_vec++; if (sum !== '0) begin n_err++; $display("FAIL rst_sum: got %h want 0000", sum); end
    n_vec++; if ({cout, ovf} !== 2'b00) begin n_err++; $display("FAIL rst_flags: got %b%b want 00", cout, ovf); end
    n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [W-1:0] ta[5] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'hFFFF};
    logic [W-1:0] tb_v[5] = '{16'h0001, 16'h0001, 16'h0001, 16'h8000, 16'h0000};
    logic         tc[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [W+1:0] te[5] = '{18'h0_0002, 18'h1_0000, 18'h2_8000, 18'h3_0000, 18'h1_0000};
    for (int i = 0; i < 5; i++) run_op(ta[i], tb_v[i], tc[i], 1'b0, te[i], W'($urandom));
  endtask

  task automatic test_cin_change();
    run_op(16'h0F0F, 16'h00F0, 1'b1, 1'b0, 18'h0_1000, 16'h1234);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x1, y1, x2, y2;
    logic [W+1:0] e1;
    int guard;
    x1 = W'($urandom); y1 = W'($urandom); x2 = W'($urandom); y2 = W'($urandom);
    e1 = ref_add(x1, y1, 1'b0);
    @(negedge clk);
    a = x1; b = y1; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    a = x2; b = y2; cin = 1'b1;
    guard = 0;
    while (out_valid !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {ovf, cout, sum} !== e1) begin
        n_err++;
        $display("FAIL hold[%0d]: got v=%b r=%b res=%h want v=1 r=0 res=%h",
                 i, out_valid, in_ready, {ovf, cout, sum}, e1);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_idle: got r=%b v=%b want 1/0", in_ready, out_valid);
    end
    out_ready = 1'b0;
    @(negedge clk);
    finish_op(ref_add(x2, y2, 1'b1), W'($urandom));
  endtask

  task automatic test_reset_mid_op();
    int guard;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hEEEE; cin = 1'b1; in_valid = 1'b1;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (sum !== '0 || cout !== 1'b0 || ovf !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL async_rst: got sum=%h c=%b o=%b v=%b r=%b want 0000 0 0 0 1",
               sum, cout, ovf, out_valid, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL post_rst[%0d]: got v=%b r=%b want 0/1", i, out_valid, in_ready);
      end
    end
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 18'h0_2345, W'($urandom));
  endtask

  task automatic test_random();
    logic [W-1:0] x, y;
    logic c;
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom); y = W'($urandom); c = 1'($urandom_range(0, 1));
      run_op(x, y, c, 1'($urandom_range(0, 1)), ref_add(x, y, c), W'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_cin_change();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
